// File: rtl/alu_ops_pkg.sv
// alu_ops_pkg: shared ALU opcode constants and the sequencer FSM encoding.
//   OP_*        : opcodes understood by the 64-bit combinational ALU
//   LAST_OPCODE : highest legal opcode; anything above is reported as an error
//   state_t     : sequencer FSM states
package alu_ops_pkg;

    localparam logic [3:0] OP_ADD      = 4'd0;
    localparam logic [3:0] OP_SUB      = 4'd1;
    localparam logic [3:0] OP_AND      = 4'd2;
    localparam logic [3:0] OP_OR       = 4'd3;
    localparam logic [3:0] OP_SLL      = 4'd4;
    localparam logic [3:0] OP_XOR      = 4'd5;
    localparam logic [3:0] OP_MUL      = 4'd6;
    localparam logic [3:0] OP_PASSB    = 4'd7;
    localparam logic [3:0] OP_SEQ      = 4'd8;
    localparam logic [3:0] OP_ROL      = 4'd9;
    localparam logic [3:0] LAST_OPCODE = OP_ROL;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= LAST_OPCODE;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU operand and response channels of the
// ALU command sequencer.
//   cmd_* : tagged command in (valid/ready)
//   alu_* : registered operands out to the ALU, result/flags back
//   rsp_* : captured result/flags/error/tag out (valid/ready)
// master = sequencer side, slave = front end + ALU + response consumer.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [4:0]       cmd_shamt;
    logic [TAG_W-1:0] cmd_tag;

    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_input1;
    logic [WIDTH-1:0] alu_input2;
    logic [4:0]       alu_shift;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_sign;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_sign;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shamt, cmd_tag,
        output cmd_ready,
        output alu_opcode, alu_input1, alu_input2, alu_shift,
        input  alu_result, alu_carry, alu_zero, alu_sign,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shamt, cmd_tag,
        input  cmd_ready,
        input  alu_opcode, alu_input1, alu_input2, alu_shift,
        output alu_result, alu_carry, alu_zero, alu_sign,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_err, rsp_tag,
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: initiator side of the 64-bit ALU operand interface.
// Takes one tagged command at a time, holds its operands on the ALU for
// SETTLE_CYCLES, captures result/flags and returns them with the tag.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : cmd / alu / rsp channels (master modport)
//   op_count  : completed responses since reset (wraps)
module alu_cmd_sequencer
    import alu_ops_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int TAG_W         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.master  bus,
    output logic [31:0]          op_count
);

    state_t           r_state, w_next;
    logic [3:0]       r_cnt;
    logic             r_err_pend;
    logic [TAG_W-1:0] r_tag;
    logic             r_cmd_ready, r_rsp_valid;
    logic [3:0]       r_alu_opcode;
    logic [WIDTH-1:0] r_alu_input1, r_alu_input2;
    logic [4:0]       r_alu_shift;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_carry, r_rsp_zero, r_rsp_sign, r_rsp_err;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [31:0]      r_op_count;

    logic w_cmd_hs, w_rsp_hs, w_capture, w_eq;

    assign w_cmd_hs  = bus.cmd_valid && r_cmd_ready;
    assign w_rsp_hs  = r_rsp_valid && bus.rsp_ready;
    assign w_capture = (r_state == S_SETTLE) && (r_cnt == 4'd0);
    assign w_eq      = (r_alu_input1 == r_alu_input2);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_cmd_hs)  w_next = S_SETTLE;
            S_SETTLE: if (w_capture) w_next = S_RESP;
            S_RESP:   if (w_rsp_hs)  w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_err_pend   <= 1'b0;
            r_tag        <= '0;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_input1 <= '0;
            r_alu_input2 <= '0;
            r_alu_shift  <= '0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_sign   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_tag    <= '0;
            r_op_count   <= '0;
        end else begin
            // Handshake flags are registered from the next state, so both
            // read 0 for the first cycle after reset.
            r_cmd_ready <= (w_next == S_IDLE);
            r_rsp_valid <= (w_next == S_RESP);

            if (w_cmd_hs) begin
                r_tag <= bus.cmd_tag;
                if (is_legal_op(bus.cmd_opcode)) begin
                    r_alu_opcode <= bus.cmd_opcode;
                    r_alu_input1 <= bus.cmd_a;
                    r_alu_input2 <= bus.cmd_b;
                    r_alu_shift  <= bus.cmd_shamt;
                    r_cnt        <= 4'(SETTLE_CYCLES);
                    r_err_pend   <= 1'b0;
                end else begin
                    // Illegal opcode: pass through SETTLE with an empty
                    // counter so the error response lands one edge later.
                    r_cnt        <= 4'd0;
                    r_err_pend   <= 1'b1;
                end
            end else if (r_state == S_SETTLE && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_capture) begin
                r_rsp_tag <= r_tag;
                r_rsp_err <= r_err_pend;
                if (r_err_pend) begin
                    r_rsp_result <= '0;
                    r_rsp_carry  <= 1'b0;
                    r_rsp_zero   <= 1'b1;
                    r_rsp_sign   <= 1'b0;
                end else if (r_alu_opcode == OP_SEQ) begin
                    // Set-if-equal is resolved here; the ALU output is ignored.
                    r_rsp_result <= {{(WIDTH-1){1'b0}}, w_eq};
                    r_rsp_carry  <= 1'b0;
                    r_rsp_zero   <= !w_eq;
                    r_rsp_sign   <= 1'b0;
                end else begin
                    r_rsp_result <= bus.alu_result;
                    r_rsp_carry  <= (r_alu_opcode == OP_ADD || r_alu_opcode == OP_SUB) ?
                                    bus.alu_carry : 1'b0;
                    r_rsp_zero   <= bus.alu_zero;
                    r_rsp_sign   <= bus.alu_sign;
                end
            end

            if (w_rsp_hs) r_op_count <= r_op_count + 32'd1;
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.alu_input1 = r_alu_input1;
    assign bus.alu_input2 = r_alu_input2;
    assign bus.alu_shift  = r_alu_shift;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_sign   = r_rsp_sign;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.rsp_tag    = r_rsp_tag;
    assign op_count       = r_op_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: dut0 (SETTLE_CYCLES=1) runs the vector table
// and corner sequences; dut1 (SETTLE_CYCLES=4) runs a back-to-back stream.
module tb_alu_cmd_sequencer;
    import alu_ops_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt0 = 0;
    int   exp_cnt1 = 0;
    int   n_rsp1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_cmd_sequencer_if #(.WIDTH(64), .TAG_W(4)) if0 ();
    alu_cmd_sequencer_if #(.WIDTH(64), .TAG_W(4)) if1 ();
    logic [31:0] op_count0, op_count1;

    alu_cmd_sequencer #(.WIDTH(64), .TAG_W(4), .SETTLE_CYCLES(1))
        dut0 (.clk(clk), .rst(rst), .bus(if0), .op_count(op_count0));
    alu_cmd_sequencer #(.WIDTH(64), .TAG_W(4), .SETTLE_CYCLES(4))
        dut1 (.clk(clk), .rst(rst), .bus(if1), .op_count(op_count1));

    // Reference ALU. Non-arithmetic ops and SEQ drive deliberately junk flags
    // so that the sequencer's masking/override is observable.
    typedef struct packed {
        logic [63:0] r;
        logic        c, z, s;
    } alu_o_t;

    function automatic alu_o_t alu_f(logic [3:0] op, logic [63:0] a, logic [63:0] b, logic [4:0] sh);
        alu_o_t o;
        logic [64:0] w;
        o.c = 1'b1;
        case (op)
            OP_ADD:   begin w = {1'b0, a} + {1'b0, b}; o.r = w[63:0]; o.c = w[64]; end
            OP_SUB:   begin o.r = a - b; o.c = (a < b); end
            OP_AND:   o.r = a & b;
            OP_OR:    o.r = a | b;
            OP_SLL:   o.r = a << sh;
            OP_XOR:   o.r = a ^ b;
            OP_MUL:   o.r = a * b;
            OP_PASSB: o.r = b;
            OP_ROL:   o.r = (sh == 5'd0) ? a : ((a << sh) | (a >> (64 - int'(sh))));
            default:  o.r = 64'hDEAD_BEEF;
        endcase
        o.z = (o.r == 64'd0);
        o.s = o.r[63];
        if (op == OP_SEQ) begin o.z = 1'b0; o.s = 1'b1; end
        return o;
    endfunction

    assign {if0.alu_result, if0.alu_carry, if0.alu_zero, if0.alu_sign} =
        alu_f(if0.alu_opcode, if0.alu_input1, if0.alu_input2, if0.alu_shift);
    assign {if1.alu_result, if1.alu_carry, if1.alu_zero, if1.alu_sign} =
        alu_f(if1.alu_opcode, if1.alu_input1, if1.alu_input2, if1.alu_shift);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] pk(logic [63:0] r, logic c, logic z, logic s, logic e, logic [3:0] t);
        return {r, c, z, s, e, t};
    endfunction

    logic [71:0] q0[$];
    logic [71:0] q1[$];

    // Scoreboard: compare each accepted response against the queue head.
    always @(negedge clk) begin
        if (!rst && if0.rsp_valid && if0.rsp_ready) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rsp0_unexpected: got tag %0d want no response", if0.rsp_tag);
            end else begin
                chk("rsp0", pk(if0.rsp_result, if0.rsp_carry, if0.rsp_zero, if0.rsp_sign,
                               if0.rsp_err, if0.rsp_tag), q0.pop_front());
                chk("opcnt0", op_count0, exp_cnt0);
                exp_cnt0++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if1.rsp_valid && if1.rsp_ready) begin
            n_rsp1++;
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rsp1_unexpected: got tag %0d want no response", if1.rsp_tag);
            end else begin
                chk("rsp1", pk(if1.rsp_result, if1.rsp_carry, if1.rsp_zero, if1.rsp_sign,
                               if1.rsp_err, if1.rsp_tag), q1.pop_front());
                chk("opcnt1", op_count1, exp_cnt1);
                exp_cnt1++;
            end
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a, b;
        logic [4:0]  sh;
        logic [3:0]  tag;
        logic [63:0] er;
        logic        ec, ez, es, ee;
    } vec_t;

    vec_t tbl[15];

    // Drive one command on dut0 and push its expected response.
    task automatic send0(input vec_t v);
        int n = 0;
        if0.cmd_opcode = v.op; if0.cmd_a = v.a; if0.cmd_b = v.b;
        if0.cmd_shamt = v.sh; if0.cmd_tag = v.tag; if0.cmd_valid = 1'b1;
        @(negedge clk);
        while (!if0.cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!if0.cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            if0.cmd_valid = 1'b0;
            return;
        end
        q0.push_back(pk(v.er, v.ec, v.ez, v.es, v.ee, v.tag));
        @(posedge clk); #1;
        if0.cmd_valid = 1'b0;
    endtask

    // Edges from the handshake until rsp_valid is seen (bounded).
    task automatic wait_rsp0(output int lat);
        lat = 0;
        while (!if0.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    initial begin
        int lat;
        int hs[4];
        logic seen;
        vec_t v;

        tbl[0]  = '{OP_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, 4'd3,  64'd0, 1, 1, 0, 0};
        tbl[1]  = '{OP_SUB,   64'd5, 64'd7, 5'd0, 4'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1, 0};
        tbl[2]  = '{OP_AND,   64'hF0F0, 64'hFF00, 5'd0, 4'd2, 64'hF000, 0, 0, 0, 0};
        tbl[3]  = '{OP_OR,    64'd0, 64'd0, 5'd0, 4'd4, 64'd0, 0, 1, 0, 0};
        tbl[4]  = '{OP_SLL,   64'h0000_0001_0000_0000, 64'd0, 5'd31, 4'd5, 64'h8000_0000_0000_0000, 0, 0, 1, 0};
        tbl[5]  = '{OP_XOR,   64'hAAAA, 64'hAAAA, 5'd0, 4'd6, 64'd0, 0, 1, 0, 0};
        tbl[6]  = '{OP_MUL,   64'd3, 64'd7, 5'd0, 4'd7, 64'd21, 0, 0, 0, 0};
        tbl[7]  = '{OP_PASSB, 64'd1, 64'h8000_0000_0000_0001, 5'd0, 4'd8, 64'h8000_0000_0000_0001, 0, 0, 1, 0};
        tbl[8]  = '{OP_SEQ,   64'h1234, 64'h1234, 5'd0, 4'd9, 64'd1, 0, 0, 0, 0};
        tbl[9]  = '{OP_SEQ,   64'd5, 64'd6, 5'd0, 4'd10, 64'd0, 0, 1, 0, 0};
        tbl[10] = '{OP_ROL,   64'h8000_0000_0000_0001, 64'd0, 5'd1, 4'd11, 64'd3, 0, 0, 0, 0};
        tbl[11] = '{4'd12,    64'd7, 64'd7, 5'd3, 4'd12, 64'd0, 0, 1, 0, 1};
        tbl[12] = '{4'd15,    64'd9, 64'd9, 5'd0, 4'd14, 64'd0, 0, 1, 0, 1};
        tbl[13] = '{OP_ADD,   64'd1, 64'd2, 5'd0, 4'd13, 64'd3, 0, 0, 0, 0};
        tbl[14] = '{OP_SUB,   64'd9, 64'd9, 5'd0, 4'd15, 64'd0, 0, 1, 0, 0};

        if0.cmd_valid = 0; if0.cmd_opcode = 0; if0.cmd_a = 0; if0.cmd_b = 0;
        if0.cmd_shamt = 0; if0.cmd_tag = 0; if0.rsp_ready = 1;
        if1.cmd_valid = 0; if1.cmd_opcode = 0; if1.cmd_a = 0; if1.cmd_b = 0;
        if1.cmd_shamt = 0; if1.cmd_tag = 0; if1.rsp_ready = 1;

        // Reset state
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_outs0", {if0.cmd_ready, if0.alu_opcode, if0.alu_input1, if0.alu_shift,
                            if0.rsp_valid, if0.rsp_carry, if0.rsp_zero, if0.rsp_sign,
                            if0.rsp_err, if0.rsp_tag, op_count0}, 0);
        chk("reset_outs1", {if1.cmd_ready, if1.rsp_valid, if1.rsp_result, op_count1}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", if0.cmd_ready, 1);

        // Table: each vector alone, with latency and op_count checks
        for (int i = 0; i < 15; i++) begin
            send0(tbl[i]);
            wait_rsp0(lat);
            chk($sformatf("latency[%0d]", i), lat, tbl[i].ee ? 1 : 2);
            @(posedge clk); #1;
            chk($sformatf("opcount[%0d]", i), op_count0, exp_cnt0);
            if (i == 11 || i == 12)
                chk($sformatf("alu_held[%0d]", i), {if0.alu_opcode, if0.alu_input1},
                    {OP_ROL, 64'h8000_0000_0000_0001});
        end

        // Back-pressure after MUL 3*7
        if0.rsp_ready = 1'b0;
        v = '{OP_MUL, 64'd3, 64'd7, 5'd0, 4'd5, 64'd21, 0, 0, 0, 0};
        send0(v);
        wait_rsp0(lat);
        chk("bp_latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold[%0d]", i), {if0.rsp_valid, if0.cmd_ready, if0.rsp_result},
                {1'b1, 1'b0, 64'd21});
        end
        @(posedge clk); #1;
        if0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_opcount", op_count0, exp_cnt0);
        chk("bp_valid_drop", if0.rsp_valid, 0);

        // Reset while in SETTLE: command abandoned
        v = '{OP_ADD, 64'd2, 64'd3, 5'd0, 4'd6, 64'd5, 0, 0, 0, 0};
        send0(v);
        rst = 1'b1;
        void'(q0.pop_back());
        @(posedge clk); #1;
        chk("midrst_outs", {if0.cmd_ready, if0.alu_opcode, if0.alu_input1, if0.alu_input2,
                            if0.alu_shift, if0.rsp_valid, if0.rsp_result, if0.rsp_carry,
                            if0.rsp_zero, if0.rsp_sign, if0.rsp_err, if0.rsp_tag, op_count0}, 0);
        rst = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | if0.rsp_valid;
        end
        chk("midrst_no_rsp", seen, 0);
        v = '{OP_ADD, 64'd2, 64'd3, 5'd0, 4'd6, 64'd5, 0, 0, 0, 0};
        send0(v);
        wait_rsp0(lat);
        chk("postrst_latency", lat, 2);
        @(posedge clk); #1;
        chk("postrst_opcount", op_count0, 1);

        // Back-to-back stream on dut1 (SETTLE_CYCLES=4)
        if1.cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            if1.cmd_opcode = OP_ADD; if1.cmd_a = 64'(k); if1.cmd_b = 64'd10;
            if1.cmd_tag = 4'(k + 1);
            @(negedge clk);
            while (!if1.cmd_ready && n < 50) begin @(negedge clk); n++; end
            if (!if1.cmd_ready) begin
                chk("stream_timeout", 0, 1);
                break;
            end
            hs[k] = cyc;
            q1.push_back(pk(64'(10 + k), 0, 0, 0, 0, 4'(k + 1)));
            @(posedge clk); #1;
        end
        if1.cmd_valid = 1'b0;
        for (int k = 1; k < 4; k++)
            chk($sformatf("stream_gap[%0d]", k), hs[k] - hs[k-1], 7);
        for (int i = 0; i < 40 && n_rsp1 < 4; i++) begin @(posedge clk); #1; end
        chk("stream_rsp_count", n_rsp1, 4);
        chk("stream_opcount", op_count1, 4);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", {q0.size(), q1.size()}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
